// File: rtl/display_scan_controller.sv
// display_scan_controller
// Sequential double-dabble binary-to-BCD converter feeding a continuously
// running digit scanner. Each scan slot drives one digit enable and the
// matching one-hot code for a shared seven-segment decoder.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module display_scan_controller #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned IN_WIDTH    = 14,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                Clock,
  input  logic                ResetN,
  input  logic [IN_WIDTH-1:0] Value,
  input  logic                Load,
  output logic                Busy,
  output logic                Done,
  output logic                Overflow,
  output logic [9:0]          DigitCode,
  output logic [DIGITS-1:0]   DigitSelect
);

  // Decimal digits needed for 2^IN_WIDTH-1: floor(W*log10(2))+1.
  // The constant slightly overestimates log10(2), which at worst adds a nibble.
  localparam int unsigned BIN_NIB = (IN_WIDTH * 30103) / 100000 + 1;
  localparam int unsigned ACC_NIB = (BIN_NIB > DIGITS) ? BIN_NIB : DIGITS;
  localparam int unsigned ACC_W   = 4 * ACC_NIB;
  localparam int unsigned DISP_W  = 4 * DIGITS;
  localparam int unsigned CNT_W   = $clog2(IN_WIDTH + 1);
  localparam int unsigned PRE_W   = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [DIGITS-1:0] SEL_FIRST = DIGITS'(1);
  localparam logic [9:0]        CODE_BLANK = 10'b10_0000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_COMMIT
  } state_t;

  // Conversion FSM state
  state_t              state_q;
  logic [IN_WIDTH-1:0] shift_q;
  logic [ACC_W-1:0]    bcd_q;
  logic [CNT_W-1:0]    iter_q;
  logic                busy_q;
  logic                done_q;
  logic                ovf_q;
  logic [DISP_W-1:0]   disp_q;

  // Scanner state
  logic [PRE_W-1:0]    presc_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DIGITS-1:0]   sel_q;
  logic [9:0]          code_q;

  // Combinational helpers
  logic [ACC_W-1:0]          bcd_adj;
  logic [ACC_W+IN_WIDTH-1:0] cat_sh;
  logic [ACC_W-1:0]          bcd_nx;
  logic [IN_WIDTH-1:0]       shift_nx;
  logic                      commit_ovf;
  logic [DISP_W-1:0]         commit_disp;
  logic [DISP_W-1:0]         disp_d;
  logic [PRE_W-1:0]          presc_d;
  logic [IDX_W-1:0]          idx_d;
  logic [DIGITS-1:0]         sel_d;
  logic [9:0]                code_d;
  logic [3:0]                nib;
  logic                      blank;
`ifdef LEADING_ZERO_BLANK_EN
  logic                      run;
  logic [DIGITS-1:0]         lead_zero;
`endif

  // Map a BCD nibble onto the shared decoder's one-hot Number input.
  function automatic logic [9:0] digit_code(input logic [3:0] n, input logic blk);
    logic [9:0] c;
    c = '0;
    if (blk) begin
      c = CODE_BLANK;
    end else if (n >= 4'd1 && n <= 4'd9) begin
      c[n - 4'd1] = 1'b1;
    end
    return c;
  endfunction

  // One double-dabble iteration: add 3 to nibbles >= 5, then shift left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < ACC_NIB; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    cat_sh   = {bcd_adj, shift_q} << 1;
    bcd_nx   = cat_sh[ACC_W+IN_WIDTH-1 : IN_WIDTH];
    shift_nx = cat_sh[IN_WIDTH-1:0];
  end

  // Commit value: any nonzero nibble above the displayed ones means overflow,
  // in which case the display saturates to all nines.
  always_comb begin
    commit_ovf = 1'b0;
    for (int unsigned i = DIGITS; i < ACC_NIB; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) begin
        commit_ovf = 1'b1;
      end
    end
    commit_disp = bcd_q[DISP_W-1:0];
    if (commit_ovf) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        commit_disp[4*i +: 4] = 4'd9;
      end
    end
    disp_d = (state_q == S_COMMIT) ? commit_disp : disp_q;
  end

  // Load / convert / commit sequencing with registered status outputs.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      disp_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Load) begin
            shift_q <= Value;
            bcd_q   <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          bcd_q   <= bcd_nx;
          shift_q <= shift_nx;
          iter_q  <= iter_q + 1'b1;
          if (iter_q == CNT_W'(IN_WIDTH - 1)) begin
            state_q <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          disp_q  <= commit_disp;
          ovf_q   <= commit_ovf;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Scan slot sequencing and next enable/code. The code is taken from the
  // next display value so a commit and a slot change both land on one edge.
  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PRE_W'(REFRESH_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    sel_d        = '0;
    sel_d[idx_d] = 1'b1;
    nib          = disp_d[4*idx_d +: 4];
    blank        = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    run       = 1'b1;
    lead_zero = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      run = run & (disp_d[4*(DIGITS-1-k) +: 4] == 4'd0);
      lead_zero[DIGITS-1-k] = run;
    end
    blank = (idx_d != '0) && lead_zero[idx_d];
`endif
    code_d = digit_code(nib, blank);
  end

  // Free-running scanner registers; enable and code update together.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      presc_q <= '0;
      idx_q   <= '0;
      sel_q   <= SEL_FIRST;
      code_q  <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      code_q  <= code_d;
    end
  end

  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Overflow    = ovf_q;
  assign DigitCode   = code_q;
  assign DigitSelect = sel_q;

endmodule
